// File: rtl/ram_io_responder.sv
// Purpose: byte-wide CPU bus responder: 128 KB RAM plus I/O (rx byte read, cycle counter, tx byte queue, stop flag).
// Latency: one request per cycle; writes commit at the closing edge; read data appears on mem_din two edges later.
// Backpressure: none on the bus; tx queue drains on tx_valid&tx_ready, and a push into a full queue is dropped (tx_ovf).
module ram_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int TXQ_DEPTH  = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_end,
    output logic        tx_ovf
);
    localparam int QAW = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
    localparam int QCW = QAW + 1;

    logic [7:0]            r_ram [0:(1 << RAM_ADDR_W) - 1];
    logic [7:0]            r_s1_ram_dat;
    logic                  r_s1_vld;
    logic                  r_s1_io;
    logic [7:0]            r_s1_io_dat;
    logic [7:0]            r_mem_din;
    logic [31:0]           r_cnt;
    logic [31:0]           r_snap;
    logic [7:0]            r_q [0:TXQ_DEPTH-1];
    logic [QAW-1:0]        r_wp;
    logic [QAW-1:0]        r_rp;
    logic [QCW-1:0]        r_qcnt;
    logic                  r_end;
    logic                  r_ovf;

    logic                  w_io_rx;
    logic                  w_io_cnt;
    logic                  w_snap_rd;
    logic [7:0]            w_io_rdat;
    logic                  w_push;
    logic [7:0]            w_push_dat;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_acc;
    logic                  w_unused;

    // Only bits 17:0 of the CPU address take part in decoding.
    assign w_unused   = ^mem_a[31:18];
    assign w_io_rx    = (mem_a[17:0] == 18'h30000);
    assign w_io_cnt   = (mem_a[17:2] == 16'hC001);
    assign w_snap_rd  = !mem_wr && w_io_cnt && (mem_a[1:0] == 2'd0);

    // I/O read data; byte 0 of the counter bypasses the snapshot so the 0x30004 read sees the value being captured.
    always_comb begin
        w_io_rdat = 8'h00;
        if (w_io_rx) begin
            w_io_rdat = rx_valid ? rx_data : 8'h00;
        end else if (w_io_cnt) begin
            case (mem_a[1:0])
                2'd0:    w_io_rdat = r_cnt[7:0];
                2'd1:    w_io_rdat = r_snap[15:8];
                2'd2:    w_io_rdat = r_snap[23:16];
                default: w_io_rdat = r_snap[31:24];
            endcase
        end
    end

    assign rx_pop     = !rst_in && !mem_wr && w_io_rx && rx_valid;

    // Queue push/pop; a full queue still accepts a push when the head leaves in the same cycle.
    assign w_push     = mem_wr && ((w_io_rx && (mem_dout != 8'h00)) || (w_io_cnt && (mem_a[1:0] == 2'd0)));
    assign w_push_dat = w_io_rx ? mem_dout : 8'h00;
    assign w_full     = (r_qcnt == QCW'(TXQ_DEPTH));
    assign w_pop      = tx_valid && tx_ready;
    assign w_acc      = w_push && (!w_full || w_pop);

    assign tx_valid   = (r_qcnt != '0);
    assign tx_data    = tx_valid ? r_q[r_rp] : 8'h00;
    assign mem_din    = r_mem_din;
    assign prog_end   = r_end;
    assign tx_ovf     = r_ovf;

    // RAM array and queue storage: contents survive reset, so no reset here.
    always_ff @(posedge clk_in) begin
        if (mem_wr && !mem_a[17]) begin
            r_ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
        end
        r_s1_ram_dat <= r_ram[mem_a[RAM_ADDR_W-1:0]];
        if (w_acc) begin
            r_q[r_wp] <= w_push_dat;
        end
    end

    // Two-stage read pipeline; reset drops any read in flight so mem_din stays 0x00 after release.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s1_vld    <= 1'b0;
            r_s1_io     <= 1'b0;
            r_s1_io_dat <= 8'h00;
            r_mem_din   <= 8'h00;
        end else begin
            r_s1_vld    <= !mem_wr;
            r_s1_io     <= mem_a[17];
            r_s1_io_dat <= w_io_rdat;
            if (r_s1_vld) begin
                r_mem_din <= r_s1_io ? r_s1_io_dat : r_s1_ram_dat;
            end
        end
    end

    // Free-running cycle counter and the snapshot taken on a 0x30004 read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt  <= 32'd0;
            r_snap <= 32'd0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_snap_rd) begin
                r_snap <= r_cnt;
            end
        end
    end

    // Queue pointers, occupancy and the sticky stop/overflow flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_qcnt <= '0;
            r_end  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_wp <= r_wp + QAW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + QAW'(1);
            end
            if (w_acc && !w_pop) begin
                r_qcnt <= r_qcnt + QCW'(1);
            end else if (!w_acc && w_pop) begin
                r_qcnt <= r_qcnt - QCW'(1);
            end
            if (w_push && !w_acc) begin
                r_ovf <= 1'b1;
            end
            if (mem_wr && w_io_cnt && (mem_a[1:0] == 2'd0)) begin
                r_end <= 1'b1;
            end
        end
    end
endmodule
